// File: rtl/seven_segment_reader.sv
// Recovers BCD digits, blank/error flags and a frame pulse from a multiplexed,
// active-low seven-segment display bus by capturing each digit once it is stable.
module seven_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   error_out,
    output logic                    frame_valid
);

    typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

    localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);

    // Returns {nibble, blank, error} for a {g,f,e,d,c,b,a} active-low pattern.
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = {4'h0, 2'b00};
            7'b1111001: decode = {4'h1, 2'b00};
            7'b0100100: decode = {4'h2, 2'b00};
            7'b0110000: decode = {4'h3, 2'b00};
            7'b0011001: decode = {4'h4, 2'b00};
            7'b0010010: decode = {4'h5, 2'b00};
            7'b0000010: decode = {4'h6, 2'b00};
            7'b1111000: decode = {4'h7, 2'b00};
            7'b0000000: decode = {4'h8, 2'b00};
            7'b0010000: decode = {4'h9, 2'b00};
            7'b1111111: decode = {4'hF, 2'b10};
            default:    decode = {4'hE, 2'b01};
        endcase
    endfunction

    function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] a);
        logic [NUM_DIGITS-1:0] s;
        s = ~a;
        one_hot_low = (s != '0) && ((s & (s - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == '0);
    endfunction

    state_t                    state_q;
    logic [6:0]                seg_q;
    logic [NUM_DIGITS-1:0]     an_q;
    logic [7:0]                cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]     seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0]   digits_q;
    logic [NUM_DIGITS-1:0]     blank_q, error_q;
    logic                      frame_q;
    logic                      same, in_valid, capture;
    logic [5:0]                dec;

    // cnt_q counts how many consecutive cycles the registered pair has held.
    always_comb begin
        same     = (seg_in == seg_q) && (an_in == an_q);
        in_valid = one_hot_low(an_in);
        cnt_d    = cnt_q;
        if (!in_valid)
            cnt_d = 8'd0;
        else if (!same)
            cnt_d = 8'd1;
        else if (cnt_q < STABLE_L)
            cnt_d = cnt_q + 8'd1;
        capture = (state_q == DWELL) && (cnt_d == STABLE_L);
        dec     = decode(seg_q);
        seen_d  = seen_q | ~an_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            seg_q    <= '0;
            an_q     <= '0;
            cnt_q    <= '0;
            seen_q   <= '0;
            digits_q <= '1;
            blank_q  <= '1;
            error_q  <= '0;
            frame_q  <= 1'b0;
        end else if (clear) begin
            state_q  <= IDLE;
            seg_q    <= '0;
            an_q     <= '0;
            cnt_q    <= '0;
            seen_q   <= '0;
            digits_q <= '1;
            blank_q  <= '1;
            error_q  <= '0;
            frame_q  <= 1'b0;
        end else begin
            seg_q   <= seg_in;
            an_q    <= an_in;
            cnt_q   <= cnt_d;
            frame_q <= 1'b0;
            case (state_q)
                IDLE:    if (in_valid) state_q <= DWELL;
                DWELL: begin
                    if (!in_valid)    state_q <= IDLE;
                    else if (capture) state_q <= HELD;
                end
                HELD:    if (!same) state_q <= in_valid ? DWELL : IDLE;
                default: state_q <= IDLE;
            endcase
            if (capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (!an_q[i]) begin
                        digits_q[4*i +: 4] <= dec[5:2];
                        blank_q[i]         <= dec[1];
                        error_q[i]         <= dec[0];
                    end
                end
                // The completing capture pulses the frame and starts a new seen set.
                if (seen_d == '1) begin
                    frame_q <= 1'b1;
                    seen_q  <= '0;
                end else begin
                    seen_q  <= seen_d;
                end
            end
        end
    end

    assign digits_out  = digits_q;
    assign blank_out   = blank_q;
    assign error_out   = error_q;
    assign frame_valid = frame_q;

endmodule
